bus_arbiter: RTL and testbench

//  Shares the single Sysbus port between three cache-side clients: instruction-line read (I),

---
 rtl/bus_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_bus_arbiter.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one Sysbus port between I-read, D-read and writeback clients.
// Defining BUS_ARB_STATS_EN adds saturating grant/busy counters (stat_i/d/w, stat_busy).
module bus_arbiter #(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13,
    parameter int unsigned LINE_BEATS     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_req,
    input  logic [BUS_DATA_WIDTH-1:0] i_addr,
    input  logic [BUS_TAG_WIDTH-1:0]  i_tag,
    input  logic                      d_req,
    input  logic [BUS_DATA_WIDTH-1:0] d_addr,
    input  logic [BUS_TAG_WIDTH-1:0]  d_tag,
    input  logic                      w_req,
    input  logic [BUS_DATA_WIDTH-1:0] w_addr,
    input  logic [BUS_TAG_WIDTH-1:0]  w_tag,
    input  logic [BUS_DATA_WIDTH-1:0] w_data,
    output logic                      w_beat_ack,
    output logic                      i_rvalid,
    output logic                      d_rvalid,
    output logic [BUS_DATA_WIDTH-1:0] rdata,
    output logic                      i_done,
    output logic                      d_done,
    output logic                      w_done,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack
`ifdef BUS_ARB_STATS_EN
    ,
    output logic [31:0]               stat_i,
    output logic [31:0]               stat_d,
    output logic [31:0]               stat_w,
    output logic [31:0]               stat_busy
`endif
);

    localparam int unsigned CntW = $clog2(LINE_BEATS) + 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(LINE_BEATS - 1);

    typedef enum logic [1:0] {StIdle, StAddr, StWdata, StResp} state_t;
    typedef enum logic [1:0] {OwnI = 2'd0, OwnD = 2'd1, OwnW = 2'd2} owner_t;

    state_t          state_q, state_d;
    owner_t          owner_q, owner_d;
    owner_t          rr_last_q, rr_last_d;
    owner_t          grant;
    logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
    logic            any_req;
    logic            last_beat;
    logic            unused_resptag;

    // Responses are routed by the owner register, so the returned tag carries no information.
    assign unused_resptag = ^bus_resptag;
    assign any_req        = i_req | d_req | w_req;
    assign last_beat      = (beat_cnt_q == LastBeat);

    // First requester after the last winner, in the cyclic order I -> D -> W -> I.
    always_comb begin
        grant = OwnI;
        case (rr_last_q)
            OwnI:    grant = d_req ? OwnD : (w_req ? OwnW : OwnI);
            OwnD:    grant = w_req ? OwnW : (i_req ? OwnI : OwnD);
            default: grant = i_req ? OwnI : (d_req ? OwnD : OwnW);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            owner_q    <= OwnI;
            rr_last_q  <= OwnW;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_last_q  <= rr_last_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_last_d   = rr_last_q;
        beat_cnt_d  = beat_cnt_q;
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
        w_beat_ack  = 1'b0;
        i_rvalid    = 1'b0;
        d_rvalid    = 1'b0;
        rdata       = '0;
        i_done      = 1'b0;
        d_done      = 1'b0;
        w_done      = 1'b0;

        case (state_q)
            StIdle: begin
                if (any_req) begin
                    owner_d   = grant;
                    rr_last_d = grant;
                    state_d   = StAddr;
                end
            end
            StAddr: begin
                bus_reqcyc = 1'b1;
                case (owner_q)
                    OwnI: begin
                        bus_req    = i_addr;
                        bus_reqtag = i_tag;
                    end
                    OwnD: begin
                        bus_req    = d_addr;
                        bus_reqtag = d_tag;
                    end
                    default: begin
                        bus_req    = w_addr;
                        bus_reqtag = w_tag;
                    end
                endcase
                if (bus_reqack) begin
                    beat_cnt_d = '0;
                    state_d    = (owner_q == OwnW) ? StWdata : StResp;
                end
            end
            StWdata: begin
                bus_reqcyc = 1'b1;
                bus_req    = w_data;
                bus_reqtag = w_tag;
                w_beat_ack = bus_reqack;
                if (bus_reqack) begin
                    beat_cnt_d = beat_cnt_q + CntW'(1);
                    if (last_beat) begin
                        w_done  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StResp: begin
                bus_respack = bus_respcyc;
                rdata       = bus_resp;
                i_rvalid    = bus_respcyc && (owner_q == OwnI);
                d_rvalid    = bus_respcyc && (owner_q == OwnD);
                if (bus_respcyc) begin
                    beat_cnt_d = beat_cnt_q + CntW'(1);
                    if (last_beat) begin
                        i_done  = (owner_q == OwnI);
                        d_done  = (owner_q == OwnD);
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs go quiet in the reset cycle itself, dropping any in-flight beat.
        if (reset) begin
            bus_reqcyc  = 1'b0;
            bus_req     = '0;
            bus_reqtag  = '0;
            bus_respack = 1'b0;
            w_beat_ack  = 1'b0;
            i_rvalid    = 1'b0;
            d_rvalid    = 1'b0;
            rdata       = '0;
            i_done      = 1'b0;
            d_done      = 1'b0;
            w_done      = 1'b0;
        end
    end

`ifdef BUS_ARB_STATS_EN
    logic grant_fire;
    assign grant_fire = (state_q == StIdle) && any_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_i    <= '0;
            stat_d    <= '0;
            stat_w    <= '0;
            stat_busy <= '0;
        end else begin
            if (grant_fire && (grant == OwnI) && (stat_i != '1)) stat_i <= stat_i + 32'd1;
            if (grant_fire && (grant == OwnD) && (stat_d != '1)) stat_d <= stat_d + 32'd1;
            if (grant_fire && (grant == OwnW) && (stat_w != '1)) stat_w <= stat_w + 32'd1;
            if ((state_q != StIdle) && (stat_busy != '1)) stat_busy <= stat_busy + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomised bench for bus_arbiter: transaction-level reference model plus directed scenarios.
// Stats checks are compiled in when BUS_ARB_STATS_EN is defined.
module tb_bus_arbiter;
    localparam int BDW = 64;
    localparam int BTW = 13;
    localparam int LB  = 8;
    localparam int MIdle = 0, MAddr = 1, MWrite = 2, MRead = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic           i_req, d_req, w_req;
    logic [BDW-1:0] i_addr, d_addr, w_addr, w_data;
    logic [BTW-1:0] i_tag, d_tag, w_tag;
    logic           w_beat_ack, i_rvalid, d_rvalid, i_done, d_done, w_done;
    logic [BDW-1:0] rdata;
    logic           bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
    logic [BDW-1:0] bus_req, bus_resp;
    logic [BTW-1:0] bus_reqtag, bus_resptag;
`ifdef BUS_ARB_STATS_EN
    logic [31:0]    stat_i, stat_d, stat_w, stat_busy;
`endif

    always #5 clk = ~clk;

    bus_arbiter #(
        .BUS_DATA_WIDTH(BDW),
        .BUS_TAG_WIDTH (BTW),
        .LINE_BEATS    (LB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_tag      (i_tag),
        .d_req      (d_req),
        .d_addr     (d_addr),
        .d_tag      (d_tag),
        .w_req      (w_req),
        .w_addr     (w_addr),
        .w_tag      (w_tag),
        .w_data     (w_data),
        .w_beat_ack (w_beat_ack),
        .i_rvalid   (i_rvalid),
        .d_rvalid   (d_rvalid),
        .rdata      (rdata),
        .i_done     (i_done),
        .d_done     (d_done),
        .w_done     (w_done),
        .bus_reqcyc (bus_reqcyc),
        .bus_req    (bus_req),
        .bus_reqtag (bus_reqtag),
        .bus_reqack (bus_reqack),
        .bus_respcyc(bus_respcyc),
        .bus_resp   (bus_resp),
        .bus_resptag(bus_resptag),
        .bus_respack(bus_respack)
`ifdef BUS_ARB_STATS_EN
        ,
        .stat_i     (stat_i),
        .stat_d     (stat_d),
        .stat_w     (stat_w),
        .stat_busy  (stat_busy)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Client side: index 0 = I, 1 = D, 2 = W.
    bit             creq [3];
    logic [BDW-1:0] caddr [3];
    logic [BTW-1:0] ctag [3];
    logic [BDW-1:0] wbase;
    int             wbeat;
    bit             persist;
    int             p_req, p_resp, ack_stall, stall_cnt;

    // Reference model of the transaction in progress.
    int m_phase, m_owner, m_rr, m_beats, m_completed, busy_cycles;

    int             cnt_rv [3];
    int             cnt_done [3];
    int             cnt_wack, cnt_respack;
    logic [BTW-1:0] obs_tags [$];
    logic [BDW-1:0] obs_wdata [$];
    bit             prev_reqcyc, prev_wack;
    bit             prev_done [3];

    task automatic clear_obs();
        for (int k = 0; k < 3; k++) begin
            cnt_rv[k]   = 0;
            cnt_done[k] = 0;
        end
        cnt_wack    = 0;
        cnt_respack = 0;
        m_completed = 0;
        obs_tags.delete();
        obs_wdata.delete();
    endtask

    // One clock cycle: client/slave stimulus, comparison against the model, model advance.
    task automatic tick();
        logic [7:0]         exp_ctl, got_ctl;
        logic [BDW+BTW-1:0] exp_bus;
        bit                 last;
        int                 nxt;
        @(posedge clk);
        #1;
        if (prev_wack) wbeat++;
        for (int k = 0; k < 3; k++) begin
            if (prev_done[k]) begin
                if (!persist) creq[k] = 1'b0;
                if (k == 2) wbeat = 0;
            end
            if (!creq[k] && int'($urandom_range(99)) < p_req) begin
                creq[k]  = 1'b1;
                caddr[k] = {$urandom, $urandom};
                ctag[k]  = BTW'($urandom);
                if (k == 2) wbase = {$urandom, $urandom};
            end
        end
        i_req  = creq[0];
        i_addr = caddr[0];
        i_tag  = ctag[0];
        d_req  = creq[1];
        d_addr = caddr[1];
        d_tag  = ctag[1];
        w_req  = creq[2];
        w_addr = caddr[2];
        w_tag  = ctag[2];
        w_data = wbase + 64'(wbeat);
        bus_respcyc = int'($urandom_range(99)) < p_resp;
        bus_resp    = {$urandom, $urandom};
        bus_resptag = BTW'($urandom);
        bus_reqack  = 1'b0;
        if (bus_reqcyc) begin
            if (ack_stall < 0) begin
                bus_reqack = ($urandom_range(1) == 1);
            end else if (stall_cnt >= ack_stall) begin
                bus_reqack = 1'b1;
                stall_cnt  = 0;
            end else begin
                stall_cnt++;
            end
        end
        #1;

        // ctl = {reqcyc, respack, w_beat_ack, i_rvalid, d_rvalid, i_done, d_done, w_done}
        exp_ctl = '0;
        exp_bus = '0;
        last    = 1'b0;
        if (!reset) begin
            case (m_phase)
                MAddr: begin
                    exp_ctl[7] = 1'b1;
                    exp_bus    = {caddr[m_owner], ctag[m_owner]};
                end
                MWrite: begin
                    exp_ctl[7] = 1'b1;
                    exp_bus    = {w_data, ctag[2]};
                    exp_ctl[5] = bus_reqack;
                    last       = bus_reqack && (m_beats == LB - 1);
                    exp_ctl[0] = last;
                end
                MRead: begin
                    exp_ctl[6] = bus_respcyc;
                    if (m_owner == 0) exp_ctl[4] = bus_respcyc;
                    else exp_ctl[3] = bus_respcyc;
                    last = bus_respcyc && (m_beats == LB - 1);
                    if (last) exp_ctl[2 - m_owner] = 1'b1;
                end
                default: ;
            endcase
        end
        got_ctl = {bus_reqcyc, bus_respack, w_beat_ack, i_rvalid, d_rvalid, i_done, d_done, w_done};
        n_checks++;
        if (got_ctl !== exp_ctl)
            $display("FAIL ctl t=%0t got=%b exp=%b", $time, got_ctl, exp_ctl);
        else n_pass++;
        if (exp_ctl[7]) begin
            n_checks++;
            if ({bus_req, bus_reqtag} !== exp_bus)
                $display("FAIL bus_req t=%0t got=%h exp=%h", $time, {bus_req, bus_reqtag}, exp_bus);
            else n_pass++;
        end
        if (exp_ctl[4] || exp_ctl[3]) begin
            n_checks++;
            if (rdata !== bus_resp)
                $display("FAIL rdata t=%0t got=%h exp=%h", $time, rdata, bus_resp);
            else n_pass++;
        end

        cnt_rv[0]   += int'(i_rvalid);
        cnt_rv[1]   += int'(d_rvalid);
        cnt_done[0] += int'(i_done);
        cnt_done[1] += int'(d_done);
        cnt_done[2] += int'(w_done);
        cnt_wack    += int'(w_beat_ack);
        cnt_respack += int'(bus_respack);
        if (bus_reqcyc && !prev_reqcyc) obs_tags.push_back(bus_reqtag);
        if (w_beat_ack) obs_wdata.push_back(bus_req);
        prev_reqcyc  = bus_reqcyc;
        prev_wack    = w_beat_ack;
        prev_done[0] = i_done;
        prev_done[1] = d_done;
        prev_done[2] = w_done;

        if (!reset && m_phase != MIdle) busy_cycles++;
        if (reset) begin
            m_phase     = MIdle;
            m_rr        = 2;
            m_beats     = 0;
            busy_cycles = 0;
            stall_cnt   = 0;
        end else begin
            case (m_phase)
                MIdle: begin
                    if (creq[0] || creq[1] || creq[2]) begin
                        nxt = m_rr;
                        for (int s = 0; s < 3; s++) begin
                            nxt = (nxt + 1) % 3;
                            if (creq[nxt]) break;
                        end
                        m_owner = nxt;
                        m_rr    = nxt;
                        m_phase = MAddr;
                    end
                end
                MAddr: begin
                    if (bus_reqack) begin
                        m_beats = 0;
                        m_phase = (m_owner == 2) ? MWrite : MRead;
                    end
                end
                MWrite: if (bus_reqack) m_beats++;
                MRead:  if (bus_respcyc) m_beats++;
                default: ;
            endcase
            if (last) begin
                m_phase = MIdle;
                m_completed++;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            creq[k]      = 1'b0;
            caddr[k]     = '0;
            ctag[k]      = '0;
            prev_done[k] = 1'b0;
        end
        persist     = 1'b0;
        p_req       = 0;
        stall_cnt   = 0;
        wbeat       = 0;
        wbase       = '0;
        prev_reqcyc = 1'b0;
        prev_wack   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        clear_obs();
    endtask

    task automatic test_reset();
        p_resp    = 100;
        ack_stall = 0;
        do_reset();
        tick();
        n_checks++;
        if ({bus_reqcyc, bus_respack, w_beat_ack, i_rvalid, d_rvalid, i_done, d_done, w_done,
             bus_req, bus_reqtag, rdata} !== '0)
            $display("FAIL reset_outputs reqcyc=%b respack=%b req=%h rdata=%h exp all zero",
                     bus_reqcyc, bus_respack, bus_req, rdata);
        else n_pass++;
    endtask

    task automatic test_single_read();
        do_reset();
        p_resp    = 60;
        ack_stall = 2;
        creq[0]   = 1'b1;
        caddr[0]  = 64'h1000;
        ctag[0]   = 13'h011;
        tick();
        tick();
        n_checks++;
        if ({bus_reqcyc, bus_req, bus_reqtag} !== {1'b1, 64'h1000, 13'h011})
            $display("FAIL read_addr got=%b/%h/%h exp=1/1000/011", bus_reqcyc, bus_req, bus_reqtag);
        else n_pass++;
        for (int c = 0; c < 200 && cnt_done[0] == 0; c++) tick();
        n_checks++;
        if (cnt_done[0] !== 1) $display("FAIL read_done got=%0d exp=1", cnt_done[0]);
        else n_pass++;
        n_checks++;
        if (cnt_rv[0] !== LB) $display("FAIL read_beats got=%0d exp=%0d", cnt_rv[0], LB);
        else n_pass++;
        n_checks++;
        if (cnt_respack !== LB) $display("FAIL read_respack got=%0d exp=%0d", cnt_respack, LB);
        else n_pass++;
        n_checks++;
        if (cnt_rv[1] + cnt_done[1] + cnt_done[2] + cnt_wack !== 0)
            $display("FAIL read_other_clients got=%0d exp=0",
                     cnt_rv[1] + cnt_done[1] + cnt_done[2] + cnt_wack);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [BTW-1:0] got;
        do_reset();
        persist   = 1'b1;
        ack_stall = -1;
        p_resp    = 70;
        for (int k = 0; k < 3; k++) begin
            creq[k]  = 1'b1;
            caddr[k] = 64'(k + 1) << 12;
            ctag[k]  = BTW'(k);
        end
        for (int c = 0; c < 2000 && obs_tags.size() < 7; c++) tick();
        for (int g = 0; g < 7; g++) begin
            got = (g < obs_tags.size()) ? obs_tags[g] : 'x;
            n_checks++;
            if (got !== BTW'(g % 3)) $display("FAIL rr_order[%0d] got=%h exp=%h", g, got, g % 3);
            else n_pass++;
        end
    endtask

    task automatic test_write_stall();
        logic [BDW-1:0] got;
        do_reset();
        p_resp    = 100;
        ack_stall = 3;
        wbase     = 64'hA0;
        creq[2]   = 1'b1;
        caddr[2]  = 64'h2000;
        ctag[2]   = 13'h007;
        for (int c = 0; c < 300 && cnt_done[2] == 0; c++) tick();
        n_checks++;
        if (cnt_wack !== LB) $display("FAIL write_acks got=%0d exp=%0d", cnt_wack, LB);
        else n_pass++;
        n_checks++;
        if (cnt_done[2] !== 1) $display("FAIL write_done got=%0d exp=1", cnt_done[2]);
        else n_pass++;
        n_checks++;
        if (cnt_respack !== 0) $display("FAIL write_respack got=%0d exp=0", cnt_respack);
        else n_pass++;
        for (int b = 0; b < LB; b++) begin
            got = (b < obs_wdata.size()) ? obs_wdata[b] : 'x;
            n_checks++;
            if (got !== 64'hA0 + 64'(b)) $display("FAIL write_beat[%0d] got=%h exp=%h", b, got, 8'hA0 + b);
            else n_pass++;
        end
    endtask

    task automatic test_addr_hold();
        logic [BTW-1:0] got;
        do_reset();
        p_resp    = 50;
        ack_stall = 10;
        creq[1]   = 1'b1;
        caddr[1]  = 64'hD000;
        ctag[1]   = 13'h0D1;
        tick();
        creq[0]  = 1'b1;
        caddr[0] = 64'h1100;
        ctag[0]  = 13'h0A1;
        creq[2]  = 1'b1;
        caddr[2] = 64'h2200;
        ctag[2]  = 13'h0B1;
        wbase    = 64'h500;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++;
            if ({bus_reqcyc, bus_req, bus_reqtag} !== {1'b1, 64'hD000, 13'h0D1})
                $display("FAIL addr_hold[%0d] got=%b/%h/%h exp=1/d000/0d1", c, bus_reqcyc,
                         bus_req, bus_reqtag);
            else n_pass++;
        end
        for (int c = 0; c < 300 && cnt_done[1] == 0; c++) tick();
        n_checks++;
        if (obs_tags.size() !== 1) $display("FAIL addr_hold_grants got=%0d exp=1", obs_tags.size());
        else n_pass++;
        for (int c = 0; c < 20 && obs_tags.size() < 2; c++) tick();
        got = (obs_tags.size() > 1) ? obs_tags[1] : 'x;
        n_checks++;
        if (got !== 13'h0B1) $display("FAIL addr_hold_next got=%h exp=0b1", got);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        p_resp    = 100;
        ack_stall = 0;
        creq[0]   = 1'b1;
        caddr[0]  = 64'h3000;
        ctag[0]   = 13'h033;
        for (int c = 0; c < 50 && cnt_rv[0] < 4; c++) tick();
        n_checks++;
        if (cnt_rv[0] !== 4) $display("FAIL midreset_setup got=%0d exp=4", cnt_rv[0]);
        else n_pass++;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) creq[k] = 1'b0;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if ({bus_reqcyc, bus_respack, i_rvalid, d_rvalid, i_done, d_done, w_done, rdata} !== '0)
                $display("FAIL midreset_idle[%0d] respack=%b rvalid=%b rdata=%h exp zero", c,
                         bus_respack, i_rvalid, rdata);
            else n_pass++;
        end
    endtask

`ifdef BUS_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        persist   = 1'b1;
        ack_stall = -1;
        p_resp    = 80;
        for (int k = 0; k < 3; k++) begin
            creq[k]  = 1'b1;
            caddr[k] = 64'(k + 4) << 12;
            ctag[k]  = BTW'(k);
        end
        for (int c = 0; c < 3000 && obs_tags.size() < 6; c++) tick();
        creq[0] = 1'b0;
        creq[1] = 1'b0;
        persist = 1'b0;
        for (int c = 0; c < 300 && cnt_done[2] < 2; c++) tick();
        repeat (3) tick();
        n_checks++;
        if ({stat_i, stat_d, stat_w} !== {32'd2, 32'd2, 32'd2})
            $display("FAIL stats_grants got=%0d/%0d/%0d exp=2/2/2", stat_i, stat_d, stat_w);
        else n_pass++;
        n_checks++;
        if (stat_busy !== 32'(busy_cycles))
            $display("FAIL stats_busy got=%0d exp=%0d", stat_busy, busy_cycles);
        else n_pass++;
    endtask
`endif

    task automatic test_random();
        do_reset();
        p_req     = 20;
        p_resp    = 50;
        ack_stall = -1;
        repeat (3000) tick();
        p_req = 0;
        for (int c = 0; c < 1000 && (m_phase != MIdle || creq[0] || creq[1] || creq[2]); c++)
            tick();
        n_checks++;
        if (cnt_done[0] + cnt_done[1] + cnt_done[2] !== m_completed)
            $display("FAIL random_done_total got=%0d exp=%0d",
                     cnt_done[0] + cnt_done[1] + cnt_done[2], m_completed);
        else n_pass++;
        n_checks++;
        if (m_phase != MIdle) $display("FAIL random_drain got=busy exp=idle");
        else n_pass++;
    endtask

    initial begin
        reset       = 1'b1;
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        m_phase     = MIdle;
        m_rr        = 2;
        m_owner     = 0;
        m_beats     = 0;
        busy_cycles = 0;
        clear_obs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_stall();
        test_addr_hold();
        test_reset_mid();
`ifdef BUS_ARB_STATS_EN
        test_stats();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
